calc_engine: RTL and testbench

Parametrised successor to the calculator datapath. It decodes keypad codes, holds operand entry, and chains operations (add, subtract, multiply) at a configurable width. Multiply runs as a multi-cycle sequential operation, and an overflow flag is provided. It sits between the keypad scanner (newkey/keycode) and the display driver, replacing the separate interpreter/register/arithmetic trio.

---
 rtl/calc_pkg.sv | 42 ++++
 rtl/calc_mul_seq.sv | 82 ++++++++
 rtl/calc_engine.sv | 241 ++++++++++++++++++++++++
 tb/tb_calc_engine.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : calc_pkg
//  Description : Shared keycode map, operator and state encodings for the
//                calculator engine.
//  Revision    : 1.0 - initial release
// ============================================================================
package calc_pkg;

  // Keycodes 0x00-0x0F are hex digits; 0x16-0x1F are ignored.
  localparam logic [4:0] KEY_ADD = 5'h10;
  localparam logic [4:0] KEY_SUB = 5'h11;
  localparam logic [4:0] KEY_MUL = 5'h12;
  localparam logic [4:0] KEY_EQ  = 5'h13;
  localparam logic [4:0] KEY_CE  = 5'h14;
  localparam logic [4:0] KEY_AC  = 5'h15;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_ADD  = 2'd1,
    OP_SUB  = 2'd2,
    OP_MUL  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_ENTRY_A = 2'd0,
    ST_ENTRY_B = 2'd1,
    ST_COMPUTE = 2'd2,
    ST_RESULT  = 2'd3
  } state_e;

  function automatic op_e key_to_op(input logic [4:0] key);
    case (key)
      KEY_ADD: key_to_op = OP_ADD;
      KEY_SUB: key_to_op = OP_SUB;
      KEY_MUL: key_to_op = OP_MUL;
      default: key_to_op = OP_NONE;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/calc_mul_seq.sv
`default_nettype none
// ============================================================================
//  Module      : calc_mul_seq
//  Description : Radix-2 shift-add multiplier, one partial product per cycle.
//                A start pulse loads the operands; WIDTH cycles later the
//                full product is presented together with a one-cycle done.
//  Ports       : clock, reset    - clock, async active-high reset
//                start, a, b     - launch request and operands
//                busy            - sequence in progress
//                done            - high in the final cycle of the sequence
//                product         - 2*WIDTH result, valid while done is high
//  Revision    : 1.0 - initial release
// ============================================================================
module calc_mul_seq #(
  parameter int WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);
  localparam int CNT_W = $clog2(WIDTH);

  logic               busy_q,   busy_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;
  logic [2*WIDTH-1:0] mcand_q,  mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] prod_q,   prod_d;
  logic [2*WIDTH-1:0] partial;
  logic               last_step;

  always_comb begin
    partial   = mplier_q[0] ? mcand_q : '0;
    last_step = busy_q && (cnt_q == CNT_W'(WIDTH - 1));
    busy_d    = busy_q;
    cnt_d     = cnt_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    prod_d    = prod_q;
    if (start && !busy_q) begin
      busy_d   = 1'b1;
      cnt_d    = '0;
      mcand_d  = {{WIDTH{1'b0}}, a};
      mplier_d = b;
      prod_d   = '0;
    end else if (busy_q) begin
      prod_d   = prod_q + partial;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CNT_W'(1);
      if (last_step) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
    end else begin
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
    end
  end

  // The last partial product is folded in combinationally so the caller
  // can capture the final product on the same edge that ends the sequence.
  assign busy    = busy_q;
  assign done    = last_step;
  assign product = prod_q + partial;

endmodule
`default_nettype wire

// File: rtl/calc_engine.sv
`default_nettype none
// ============================================================================
//  Module      : calc_engine
//  Description : Keypad-driven calculator datapath: operand entry, chained
//                add/sub/mul, repeat-equals and overflow flag.
//                WIDTH must be a multiple of 4 and at least 8.
//  Ports       : clock, reset - clock, async active-high reset
//                newkey       - one-cycle keypress strobe
//                keycode      - key identity, sampled with newkey
//                display      - entry, or result in RESULT/COMPUTE
//                ovf          - carry/borrow/overflow of last result
//                busy         - multiply in progress, keys ignored
//                pending_op   - operator awaiting its second operand
//  Revision    : 1.0 - initial release
// ============================================================================
module calc_engine
  import calc_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int NDIGITS = WIDTH / 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             newkey,
  input  logic [4:0]       keycode,
  output logic [WIDTH-1:0] display,
  output logic             ovf,
  output logic             busy,
  output logic [1:0]       pending_op
);
  localparam int CNT_W = $clog2(NDIGITS + 1);

  state_e             state_q,   state_d;
  logic [WIDTH-1:0]   acc_q,     acc_d;
  logic [WIDTH-1:0]   entry_q,   entry_d;
  logic [WIDTH-1:0]   last_b_q,  last_b_d;
  op_e                last_op_q, last_op_d;
  op_e                pending_q, pending_d;
  op_e                resume_q,  resume_d;   // op to latch when a multiply ends
  logic [CNT_W-1:0]   count_q,   count_d;
  logic               ovf_q,     ovf_d;
  logic               chain_q,   chain_d;    // show acc until first new digit

  logic               key_ok, is_digit, is_op;
  op_e                key_op;
  logic               go;
  op_e                go_op, go_next;
  logic [WIDTH-1:0]   go_b;
  logic [WIDTH:0]     sum, diff;
  logic               fin;
  op_e                fin_next;
  logic [WIDTH-1:0]   fin_acc;
  logic               fin_ovf;
  logic               mul_start, mul_busy, mul_done;
  logic [2*WIDTH-1:0] mul_product;

  calc_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clock   (clock),
    .reset   (reset),
    .start   (mul_start),
    .a       (acc_q),
    .b       (go_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    entry_d   = entry_q;
    last_b_d  = last_b_q;
    last_op_d = last_op_q;
    pending_d = pending_q;
    resume_d  = resume_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    chain_d   = chain_q;
    mul_start = 1'b0;
    go        = 1'b0;
    go_op     = OP_NONE;
    go_next   = OP_NONE;
    go_b      = entry_q;
    fin       = 1'b0;
    fin_next  = OP_NONE;
    fin_acc   = acc_q;
    fin_ovf   = ovf_q;

    key_ok   = newkey && (state_q != ST_COMPUTE);
    is_digit = !keycode[4];
    key_op   = key_to_op(keycode);
    is_op    = (key_op != OP_NONE);

    if (key_ok) begin
      if (is_digit) begin
        if (state_q == ST_RESULT) begin
          entry_d = {{(WIDTH-4){1'b0}}, keycode[3:0]};
          count_d = CNT_W'(1);
          ovf_d   = 1'b0;
          chain_d = 1'b0;
          state_d = ST_ENTRY_A;
        end else if (count_q < CNT_W'(NDIGITS)) begin
          entry_d = {entry_q[WIDTH-5:0], keycode[3:0]};
          count_d = count_q + CNT_W'(1);
          chain_d = 1'b0;
          if (state_q == ST_ENTRY_A && count_q == '0) ovf_d = 1'b0;
        end
      end else if (is_op) begin
        case (state_q)
          ST_ENTRY_A: begin
            acc_d     = entry_q;
            pending_d = key_op;
            entry_d   = '0;
            count_d   = '0;
            chain_d   = 1'b0;
            state_d   = ST_ENTRY_B;
          end
          ST_ENTRY_B: begin
            if (count_q == '0) begin
              pending_d = key_op;
            end else begin
              go      = 1'b1;
              go_op   = pending_q;
              go_next = key_op;
              entry_d = '0;
              count_d = '0;
            end
          end
          ST_RESULT: begin
            pending_d = key_op;
            entry_d   = '0;
            count_d   = '0;
            chain_d   = 1'b1;
            state_d   = ST_ENTRY_B;
          end
          default: ;
        endcase
      end else if (keycode == KEY_EQ) begin
        if (state_q == ST_ENTRY_B) begin
          // With no second operand typed, acc is repeated with itself.
          go_b      = (count_q == '0) ? acc_q : entry_q;
          last_b_d  = go_b;
          last_op_d = pending_q;
          go        = 1'b1;
          go_op     = pending_q;
          entry_d   = '0;
          count_d   = '0;
        end else if (state_q == ST_RESULT) begin
          go_b  = last_b_q;
          go    = 1'b1;
          go_op = last_op_q;
        end
      end else if (keycode == KEY_CE) begin
        entry_d = '0;
        count_d = '0;
      end else if (keycode == KEY_AC) begin
        state_d   = ST_ENTRY_A;
        acc_d     = '0;
        entry_d   = '0;
        last_b_d  = '0;
        last_op_d = OP_NONE;
        pending_d = OP_NONE;
        resume_d  = OP_NONE;
        count_d   = '0;
        ovf_d     = 1'b0;
        chain_d   = 1'b0;
      end
    end

    sum  = {1'b0, acc_q} + {1'b0, go_b};
    diff = {1'b0, acc_q} - {1'b0, go_b};

    if (go) begin
      case (go_op)
        OP_ADD: begin
          fin = 1'b1; fin_acc = sum[WIDTH-1:0];  fin_ovf = sum[WIDTH];  fin_next = go_next;
        end
        OP_SUB: begin
          fin = 1'b1; fin_acc = diff[WIDTH-1:0]; fin_ovf = diff[WIDTH]; fin_next = go_next;
        end
        OP_MUL: begin
          mul_start = 1'b1;
          resume_d  = go_next;
          state_d   = ST_COMPUTE;
        end
        default: ;
      endcase
    end

    if (state_q == ST_COMPUTE && mul_done) begin
      fin      = 1'b1;
      fin_acc  = mul_product[WIDTH-1:0];
      fin_ovf  = |mul_product[2*WIDTH-1:WIDTH];
      fin_next = resume_q;
    end

    // A result either ends the calculation (RESULT) or, when chained,
    // arms the next operator and waits for its operand.
    if (fin) begin
      acc_d     = fin_acc;
      ovf_d     = fin_ovf;
      pending_d = fin_next;
      chain_d   = (fin_next != OP_NONE);
      state_d   = (fin_next == OP_NONE) ? ST_RESULT : ST_ENTRY_B;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_ENTRY_A;
      acc_q     <= '0;
      entry_q   <= '0;
      last_b_q  <= '0;
      last_op_q <= OP_NONE;
      pending_q <= OP_NONE;
      resume_q  <= OP_NONE;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      chain_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      entry_q   <= entry_d;
      last_b_q  <= last_b_d;
      last_op_q <= last_op_d;
      pending_q <= pending_d;
      resume_q  <= resume_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      chain_q   <= chain_d;
    end
  end

  assign display = (state_q == ST_RESULT || state_q == ST_COMPUTE ||
                    (state_q == ST_ENTRY_B && chain_q && count_q == '0)) ? acc_q : entry_q;
  assign ovf        = ovf_q;
  assign busy       = mul_busy;
  assign pending_op = pending_q;

endmodule
`default_nettype wire

// File: tb/tb_calc_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_calc_engine
//  Description : Self-checking bench for calc_engine (WIDTH=16); expected
//                outputs are queued as keys are driven and popped when the
//                DUT has produced its response.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_calc_engine;
  import calc_pkg::*;

  localparam int WIDTH = 16;

  logic             clock = 1'b0;
  logic             reset;
  logic             newkey;
  logic [4:0]       keycode;
  logic [WIDTH-1:0] display;
  logic             ovf;
  logic             busy;
  logic [1:0]       pending_op;

  typedef struct packed {
    logic [WIDTH-1:0] disp;
    logic             ovf;
    logic             busy;
    logic [1:0]       pend;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  calc_engine #(.WIDTH(WIDTH), .NDIGITS(WIDTH / 4)) dut (
    .clock      (clock),
    .reset      (reset),
    .newkey     (newkey),
    .keycode    (keycode),
    .display    (display),
    .ovf        (ovf),
    .busy       (busy),
    .pending_op (pending_op)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic press(input logic [4:0] k);
    @(negedge clock);
    newkey  = 1'b1;
    keycode = k;
    @(negedge clock);
    newkey  = 1'b0;
    keycode = 5'h1F;
  endtask

  task automatic expect_out(input logic [WIDTH-1:0] d, input logic o, input logic [1:0] p);
    exp_t e;
    e.disp = d; e.ovf = o; e.busy = 1'b0; e.pend = p;
    sb_q.push_back(e);
  endtask

  task automatic compare_out(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      check({tag, ".sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check({tag, ".display"}, 32'(display),    32'(e.disp));
      check({tag, ".ovf"},     32'(ovf),        32'(e.ovf));
      check({tag, ".busy"},    32'(busy),       32'(e.busy));
      check({tag, ".pend"},    32'(pending_op), 32'(e.pend));
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 200) begin
      @(negedge clock);
      n++;
    end
    check({tag, ".idle_timeout"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    reset   = 1'b1;
    newkey  = 1'b0;
    keycode = 5'h1F;
    repeat (3) @(negedge clock);
    expect_out(16'h0000, 1'b0, 2'd0);
    compare_out("reset");
    reset = 1'b0;

    // 0x12 + 0x34 with one-cycle latency after equals
    press(5'h01); press(5'h02); press(KEY_ADD);
    expect_out(16'h0000, 1'b0, 2'd1);
    compare_out("t1_opkey");
    press(5'h03); press(5'h04);
    expect_out(16'h0034, 1'b0, 2'd1);
    compare_out("t1_entry");
    press(KEY_EQ);
    expect_out(16'h0012 + 16'h0034, 1'b0, 2'd0);
    compare_out("t1_eq");

    // 5 - 7 borrows; a new digit clears ovf
    press(5'h05); press(KEY_SUB); press(5'h07); press(KEY_EQ);
    expect_out(16'hFFFE, 1'b1, 2'd0);
    compare_out("t2_sub");
    press(5'h09);
    expect_out(16'h0009, 1'b0, 2'd0);
    compare_out("t2_digit");

    // 0x100 * 0x100 overflows; keys during busy are discarded
    press(KEY_AC);
    press(5'h01); press(5'h00); press(5'h00); press(KEY_MUL);
    press(5'h01); press(5'h00); press(5'h00); press(KEY_EQ);
    n = 0;
    while (busy && n < 100) begin
      n++;
      newkey  = 1'b1;
      keycode = n[0] ? 5'h07 : KEY_AC;
      @(negedge clock);
    end
    newkey  = 1'b0;
    keycode = 5'h1F;
    check("t3_busy_cycles", 32'(n), 32'd16);
    expect_out(16'h0000, 1'b1, 2'd0);
    compare_out("t3_mul_ovf");

    // small multiply, no overflow
    press(KEY_AC);
    press(5'h03); press(KEY_MUL); press(5'h05); press(KEY_EQ);
    wait_idle("t3b");
    expect_out(16'h000F, 1'b0, 2'd0);
    compare_out("t3b_mul");

    // add carry out at the top of the range
    press(KEY_AC);
    press(5'h0F); press(5'h0F); press(5'h0F); press(5'h0F);
    press(KEY_ADD); press(5'h01); press(KEY_EQ);
    expect_out(16'h0000, 1'b1, 2'd0);
    compare_out("t3c_carry");

    // op replacement, chaining, repeat equals
    press(KEY_AC);
    press(5'h02); press(KEY_ADD); press(KEY_SUB);
    expect_out(16'h0000, 1'b0, 2'd2);
    compare_out("t4_replace");
    press(KEY_ADD); press(5'h03); press(KEY_ADD);
    expect_out(16'h0005, 1'b0, 2'd1);
    compare_out("t4_chain");
    press(5'h04); press(KEY_EQ);
    expect_out(16'h0009, 1'b0, 2'd0);
    compare_out("t4_eq");
    press(KEY_EQ);
    expect_out(16'h000D, 1'b0, 2'd0);
    compare_out("t4_repeat");

    // digit saturation, CE, AC
    press(KEY_AC);
    press(5'h01); press(5'h02); press(5'h03); press(5'h04); press(5'h05);
    expect_out(16'h1234, 1'b0, 2'd0);
    compare_out("t5_saturate");
    press(KEY_CE);
    expect_out(16'h0000, 1'b0, 2'd0);
    compare_out("t5_ce");
    press(5'h06); press(KEY_ADD); press(KEY_AC);
    expect_out(16'h0000, 1'b0, 2'd0);
    compare_out("t5_ac");

    // chained multiply latches the new op at completion
    press(5'h03); press(KEY_MUL); press(5'h04); press(KEY_ADD);
    wait_idle("t7");
    expect_out(16'h000C, 1'b0, 2'd1);
    compare_out("t7_chain_mul");

    // reset aborts a multiply in flight
    press(KEY_AC);
    press(5'h02); press(KEY_MUL); press(5'h03); press(KEY_EQ);
    repeat (4) @(negedge clock);
    check("t6_busy_before_reset", 32'(busy), 32'd1);
    #1 reset = 1'b1;
    #1;
    expect_out(16'h0000, 1'b0, 2'd0);
    compare_out("t6_async_reset");
    @(negedge clock);
    reset = 1'b0;
    press(5'h03); press(KEY_ADD); press(5'h04); press(KEY_EQ);
    expect_out(16'h0007, 1'b0, 2'd0);
    compare_out("t6_after_reset");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
